alu_issue_stage: RTL

- Produces the 4-bit ALU Operation code and the SrcA/SrcB operands consumed by the ALU. It is the encoder side of the ALU Operation interface.
- Decodes ALUOp/funct3/funct7 from the ID stage and registers the result as the ID/EX boundary for ALU controls.
- Uses valid/ready handshakes on both sides, with a 2-entry skid buffer so the upstream ready is fully registered.
- Supports flush for branch redirect.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_op_decode.sv | 50 +++++
 rtl/alu_issue_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU issue stage: operation codes,
// ALUOp/funct3/funct7 constants and the ID/EX payload carried through the skid buffer.
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    OP_AND     = 4'b0000,
    OP_XOR     = 4'b0001,
    OP_SUB     = 4'b0010,
    OP_OR      = 4'b0011,
    OP_ADD     = 4'b0100,
    OP_EQ      = 4'b1000,
    OP_SLL     = 4'b1001,
    OP_ILLEGAL = 4'b1111
  } alu_op_e;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e           op;
    logic              invert;
    logic              illegal;
    logic [DATA_W-1:0] srca;
    logic [DATA_W-1:0] srcb;
  } issue_payload_t;

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational decode of ALUOp/funct3/funct7 into the ALU operation code,
// the BNE invert flag and the illegal-encoding flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output alu_op_e    op_o,
  output logic       invert_o,
  output logic       illegal_o
);

  logic f7_zero;
  assign f7_zero = (funct7_i == F7_ZERO);

  always_comb begin
    op_o     = OP_ILLEGAL;
    invert_o = 1'b0;
    case (aluop_i)
      ALUOP_MEM: op_o = OP_ADD;
      ALUOP_BR: begin
        case (funct3_i)
          F3_BEQ: op_o = OP_EQ;
          F3_BNE: begin
            op_o     = OP_EQ;
            invert_o = 1'b1;
          end
          default: op_o = OP_ILLEGAL;
        endcase
      end
      default: begin
        // R and I share decode; for I-type funct7 holds immediate bits on ADDI
        case (funct3_i)
          F3_ADD_SUB: begin
            if (aluop_i == ALUOP_I || f7_zero) op_o = OP_ADD;
            else if (funct7_i == F7_ALT)       op_o = OP_SUB;
          end
          F3_AND: if (f7_zero) op_o = OP_AND;
          F3_OR:  if (f7_zero) op_o = OP_OR;
          F3_XOR: if (f7_zero) op_o = OP_XOR;
          F3_SLL: if (f7_zero) op_o = OP_SLL;
          default: op_o = OP_ILLEGAL;
        endcase
      end
    endcase
    illegal_o = (op_o == OP_ILLEGAL);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX boundary for ALU controls: decodes the operation, selects SrcB and holds
// the result in a main register backed by a skid register so in_ready is registered.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_W,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_aluop,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic                     in_alusrc,
  input  logic [DATA_WIDTH-1:0]    in_rs1,
  input  logic [DATA_WIDTH-1:0]    in_rs2,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_invert,
  output logic                     out_illegal
);

  alu_op_e        dec_op;
  logic           dec_invert;
  logic           dec_illegal;
  issue_payload_t new_pl;

  issue_payload_t main_q, main_d;
  issue_payload_t skid_q, skid_d;
  logic           main_vld_q, main_vld_d;
  logic           skid_vld_q, skid_vld_d;
  logic           accept, xfer;

  alu_op_decode u_decode (
    .aluop_i   (in_aluop),
    .funct3_i  (in_funct3),
    .funct7_i  (in_funct7),
    .op_o      (dec_op),
    .invert_o  (dec_invert),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    new_pl.op      = dec_op;
    new_pl.invert  = dec_invert;
    new_pl.illegal = dec_illegal;
    new_pl.srca    = in_rs1;
    new_pl.srcb    = in_alusrc ? in_imm : in_rs2;
  end

  // skid empty is exactly when a new entry can be taken
  assign accept = in_valid & ~skid_vld_q;
  assign xfer   = main_vld_q & out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || xfer) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = new_pl;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = new_pl;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
    skid_q <= skid_d;
  end

  assign in_ready    = ~skid_vld_q;
  assign out_valid   = main_vld_q;
  assign SrcA        = main_q.srca;
  assign SrcB        = main_q.srcb;
  assign Operation   = main_q.op;
  assign out_invert  = main_q.invert;
  assign out_illegal = main_q.illegal;

endmodule
